// File: rtl/arq_frame_tx.sv
// ARQ frame transmitter: buffers one frame, serialises it LSB-first at BAUD_DIV ticks per bit,
// then optionally waits for a serial ACK and replays the buffered frame on a bad ACK or timeout.
module arq_frame_tx #(
  parameter int FRAME_BYTES = 4166,
  parameter int ADDR_W      = 13,
  parameter int BAUD_DIV    = 20,
  parameter int ACK_TIMEOUT = 4096,
  parameter int MAX_RETRY   = 3,
  parameter int RETRY_W     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_baud_tick,
  input  logic [7:0]         i_frame_data,
  input  logic               i_frame_valid,
  input  logic               i_frame_sof,
  output logic               o_frame_ready,
  input  logic               i_arq_en,
  input  logic               i_ack_serial,
  output logic               o_tx_serial,
  output logic               o_busy,
  output logic               o_retrans,
  output logic               o_send_done,
  output logic               o_send_fail,
  output logic [RETRY_W-1:0] o_retry_cnt
);
  localparam int TICK_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SEND, S_ACK_WAIT, S_ACK_READ, S_RETRY, S_DONE, S_FAIL
  } state_t;

  state_t              r_state;
  logic [7:0]          r_mem [FRAME_BYTES];
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_bit;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_arq, r_ack_ok, r_stop, r_sync1, r_sync2;
  logic                r_tx, r_ready, r_retrans, r_done, r_fail;
  logic [RETRY_W-1:0]  r_retry;

  logic                w_accept, w_wr_en, w_tick_mid, w_tick_last, w_last_byte;
  logic                w_next_bit, w_first_bit;
  logic [ADDR_W-1:0]   w_wr_addr, w_rd_addr;
  logic [2:0]          w_rd_bit;

  assign w_accept    = i_frame_valid & r_ready;
  assign w_tick_mid  = i_baud_tick & (r_tick_cnt == TICK_W'(BAUD_DIV / 2));
  assign w_tick_last = i_baud_tick & (r_tick_cnt == TICK_W'(BAUD_DIV - 1));
  assign w_last_byte = (r_addr == ADDR_W'(FRAME_BYTES - 1));
  assign w_wr_en     = w_accept & ~i_rst &
                       (((r_state == S_IDLE) & i_frame_sof) | (r_state == S_FILL));
  assign w_wr_addr   = (r_state == S_FILL) ? r_addr : '0;
  // Look one bit ahead so the next bit is ready at the period boundary.
  assign w_rd_addr   = (r_bit == 3'd7) ? r_addr + 1'b1 : r_addr;
  assign w_rd_bit    = r_bit + 3'd1;
  assign w_next_bit  = r_mem[w_rd_addr][w_rd_bit];
  assign w_first_bit = r_mem[0][0];

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= i_frame_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_bit      <= '0;
      r_tick_cnt <= '0;
      r_to_cnt   <= '0;
      r_arq      <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_stop     <= 1'b0;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_tx       <= 1'b0;
      r_ready    <= 1'b0;
      r_retrans  <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_retry    <= '0;
    end else begin
      r_sync1   <= i_ack_serial;
      r_sync2   <= r_sync1;
      r_retrans <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      if (i_baud_tick) r_tick_cnt <= w_tick_last ? '0 : r_tick_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept && i_frame_sof) begin
            r_state    <= S_FILL;
            r_addr     <= ADDR_W'(1);
            r_arq      <= i_arq_en;
            r_retry    <= '0;
            r_tick_cnt <= '0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            if (w_last_byte) begin
              r_state    <= S_SEND;
              r_ready    <= 1'b0;
              r_addr     <= '0;
              r_bit      <= '0;
              r_tx       <= w_first_bit;
              r_tick_cnt <= '0;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_SEND: begin
          if (w_tick_last) begin
            if ((r_bit == 3'd7) && w_last_byte) begin
              r_tx       <= 1'b0;
              r_to_cnt   <= '0;
              r_tick_cnt <= '0;
              r_state    <= r_arq ? S_ACK_WAIT : S_DONE;
            end else begin
              r_tx  <= w_next_bit;
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_ACK_WAIT: begin
          // A start bit seen on the timeout period still takes precedence.
          if (w_tick_mid) begin
            if (!r_sync2) begin
              r_state    <= S_ACK_READ;
              r_stop     <= 1'b0;
              r_tick_cnt <= '0;
            end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
              r_state    <= S_RETRY;
              r_tick_cnt <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end
        S_ACK_READ: begin
          if (w_tick_mid && !r_stop) r_ack_ok <= r_sync2;
          if (w_tick_last) begin
            if (!r_stop) begin
              r_stop <= 1'b1;
            end else begin
              r_state    <= r_ack_ok ? S_DONE : S_RETRY;
              r_tick_cnt <= '0;
            end
          end
        end
        S_RETRY: begin
          r_tick_cnt <= '0;
          if (r_retry == RETRY_W'(MAX_RETRY)) begin
            r_state <= S_FAIL;
          end else begin
            r_retry   <= r_retry + 1'b1;
            r_retrans <= 1'b1;
            r_state   <= S_SEND;
            r_addr    <= '0;
            r_bit     <= '0;
            r_tx      <= w_first_bit;
          end
        end
        S_DONE: begin
          r_done     <= 1'b1;
          r_state    <= S_IDLE;
          r_tick_cnt <= '0;
        end
        S_FAIL: begin
          r_fail     <= 1'b1;
          r_state    <= S_IDLE;
          r_tick_cnt <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_frame_ready = r_ready;
  assign o_tx_serial   = r_tx;
  assign o_busy        = (r_state != S_IDLE);
  assign o_retrans     = r_retrans;
  assign o_send_done   = r_done;
  assign o_send_fail   = r_fail;
  assign o_retry_cnt   = r_retry;
endmodule

// File: tb/tb_arq_frame_tx.sv
// Bench for arq_frame_tx: bit-period model of the serial stream plus directed ACK scenarios.
module tb_arq_frame_tx;
  localparam int FB = 4, AW = 2, BD = 4, TO = 8, MR = 2, RW = 2;

  logic          i_clk = 1'b0, i_rst = 1'b1, i_baud_tick = 1'b0;
  logic [7:0]    i_frame_data = '0;
  logic          i_frame_valid = 1'b0, i_frame_sof = 1'b0, i_arq_en = 1'b0;
  logic          i_ack_serial = 1'b1;
  logic          o_frame_ready, o_tx_serial, o_busy, o_retrans, o_send_done, o_send_fail;
  logic [RW-1:0] o_retry_cnt;

  arq_frame_tx #(.FRAME_BYTES(FB), .ADDR_W(AW), .BAUD_DIV(BD), .ACK_TIMEOUT(TO),
                 .MAX_RETRY(MR), .RETRY_W(RW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_baud_tick(i_baud_tick),
    .i_frame_data(i_frame_data), .i_frame_valid(i_frame_valid), .i_frame_sof(i_frame_sof),
    .o_frame_ready(o_frame_ready), .i_arq_en(i_arq_en), .i_ack_serial(i_ack_serial),
    .o_tx_serial(o_tx_serial), .o_busy(o_busy), .o_retrans(o_retrans),
    .o_send_done(o_send_done), .o_send_fail(o_send_fail), .o_retry_cnt(o_retry_cnt));

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;
  int cnt_done = 0, cnt_fail = 0, cnt_retrans = 0;
  logic chk_on = 1'b0;
  logic [3:0]  ack_cfg [4];   // [3]=drive pattern, [2:0]=start,data,stop bits (bit0 first)
  logic [31:0] cap [4];       // mid-period samples of each pass
  logic [7:0]  fr [FB];

  // Model state: the frame as the spec defines it, and elapsed ticks per phase.
  logic [7:0] m_bytes [FB];
  int   m_fill = -1, m_j = 0, m_at = 0, m_pass = 0, cyc = 0;
  logic m_send = 1'b0, m_ack = 1'b0, m_arq = 1'b0;
  logic s_rst = 1'b1, s_tick = 1'b0, s_acc = 1'b0, s_sof = 1'b0, s_arq = 1'b0;
  logic [7:0] s_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    int idx;
    logic exp_tx;
    if (s_rst) begin
      m_fill = -1; m_send = 1'b0; m_ack = 1'b0; m_j = 0;
    end else begin
      if (s_tick) begin
        if (m_send) begin
          m_j++;
          if (m_j == 8 * FB * BD) begin
            m_send = 1'b0;
            if (m_arq) begin m_ack = 1'b1; m_at = 0; end
          end
        end else if (m_ack) begin
          m_at++;
        end
      end
      if (s_acc) begin
        if (m_fill < 0) begin
          if (s_sof) begin m_bytes[0] = s_data; m_fill = 1; m_arq = s_arq; m_pass = 0; end
        end else begin
          m_bytes[m_fill] = s_data;
          m_fill++;
          if (m_fill == FB) begin m_fill = -1; m_send = 1'b1; m_j = 0; end
        end
      end
      if (o_retrans) begin cnt_retrans++; m_pass++; m_send = 1'b1; m_j = 0; m_ack = 1'b0; end
      if (o_send_done) begin cnt_done++; m_ack = 1'b0; end
      if (o_send_fail) begin cnt_fail++; m_ack = 1'b0; end
    end
    if (chk_on) begin
      idx = m_j / BD;
      exp_tx = m_send ? m_bytes[idx / 8][idx % 8] : 1'b0;
      check("tx_serial", 32'(o_tx_serial), 32'(exp_tx));
      if (m_send && (m_j % BD == BD / 2) && m_pass < 4) cap[m_pass][idx] = o_tx_serial;
    end
    if (m_ack && m_pass < 4 && ack_cfg[m_pass][3] && m_at >= 3 && m_at < 15)
      i_ack_serial = ack_cfg[m_pass][(m_at - 3) / 4];
    else
      i_ack_serial = 1'b1;
    i_baud_tick = (cyc % 2 == 0);
    cyc++;
    s_rst = i_rst; s_tick = i_baud_tick; s_acc = i_frame_valid & o_frame_ready;
    s_sof = i_frame_sof; s_arq = i_arq_en; s_data = i_frame_data;
  end

  task automatic put_byte(input logic [7:0] d, input logic sof, input logic arq);
    int n = 0;
    while (!o_frame_ready && n < 100) begin @(posedge i_clk); #1; n++; end
    if (!o_frame_ready) begin
      total++; bad++;
      $display("FAIL ready_wait: got ready=0 expected 1 within 100 cycles");
    end
    i_frame_valid = 1'b1; i_frame_data = d; i_frame_sof = sof; i_arq_en = arq;
    @(posedge i_clk); #1;
    i_frame_valid = 1'b0; i_frame_sof = 1'b0;
  endtask

  task automatic load_frame(input logic arq);
    for (int i = 0; i < FB; i++) put_byte(fr[i], i == 0, arq);
  endtask

  task automatic wait_end();
    int n = 0;
    while ((cnt_done + cnt_fail) == 0 && n < 6000) begin @(posedge i_clk); #1; n++; end
    total++;
    if ((cnt_done + cnt_fail) == 0) begin
      bad++;
      $display("FAIL end_wait: got no done/fail pulse expected one within 6000 cycles");
    end
    repeat (20) @(posedge i_clk);
    #1;
  endtask

  task automatic clear_stats();
    cnt_done = 0; cnt_fail = 0; cnt_retrans = 0;
    for (int i = 0; i < 4; i++) begin cap[i] = '0; ack_cfg[i] = 4'b0000; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_tx", 32'(o_tx_serial), 32'(0));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_ready", 32'(o_frame_ready), 32'(0));
    check("rst_retry", 32'(o_retry_cnt), 32'(0));
    check("rst_done", 32'(o_send_done), 32'(0));
    i_rst = 1'b0;
    chk_on = 1'b1;
    @(posedge i_clk); #1;
    check("idle_ready", 32'(o_frame_ready), 32'(1));

    // 1) fire-and-forget
    fr[0] = 8'hA5; fr[1] = 8'h3C; fr[2] = 8'hFF; fr[3] = 8'h00;
    load_frame(1'b0);
    check("t1_busy", 32'(o_busy), 32'(1));
    check("t1_ready_low", 32'(o_frame_ready), 32'(0));
    wait_end();
    check("t1_done", 32'(cnt_done), 32'(1));
    check("t1_retrans", 32'(cnt_retrans), 32'(0));
    check("t1_retry", 32'(o_retry_cnt), 32'(0));
    check("t1_bits_lo", {16'h0, cap[0][15:0]}, 32'h3CA5);
    check("t1_bits_hi", {16'h0, cap[0][31:16]}, 32'h00FF);

    // 2) good ACK first time
    clear_stats();
    ack_cfg[0] = 4'b1010;
    load_frame(1'b1);
    wait_end();
    check("t2_done", 32'(cnt_done), 32'(1));
    check("t2_retrans", 32'(cnt_retrans), 32'(0));
    check("t2_retry", 32'(o_retry_cnt), 32'(0));

    // 3) bad ACK then good ACK
    clear_stats();
    ack_cfg[0] = 4'b1000; ack_cfg[1] = 4'b1010;
    load_frame(1'b1);
    wait_end();
    check("t3_retrans", 32'(cnt_retrans), 32'(1));
    check("t3_done", 32'(cnt_done), 32'(1));
    check("t3_fail", 32'(cnt_fail), 32'(0));
    check("t3_retry", 32'(o_retry_cnt), 32'(1));
    check("t3_replay", cap[1], 32'h00FF3CA5);
    check("t3_replay_eq", cap[1], cap[0]);

    // 4) ACK line stuck high -> timeouts and failure
    clear_stats();
    load_frame(1'b1);
    wait_end();
    check("t4_retrans", 32'(cnt_retrans), 32'(2));
    check("t4_fail", 32'(cnt_fail), 32'(1));
    check("t4_done", 32'(cnt_done), 32'(0));
    check("t4_retry", 32'(o_retry_cnt), 32'(2));
    check("t4_pass2_bits", cap[2], 32'h00FF3CA5);

    // 5) reset in the middle of the second byte
    clear_stats();
    load_frame(1'b0);
    begin
      int n = 0;
      while (!(m_send && m_j >= 10 * BD) && n < 2000) begin @(posedge i_clk); #1; n++; end
      check("t5_reached_byte2", 32'(m_send && m_j >= 10 * BD), 32'(1));
    end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("t5_tx", 32'(o_tx_serial), 32'(0));
    check("t5_busy", 32'(o_busy), 32'(0));
    check("t5_ready", 32'(o_frame_ready), 32'(0));
    check("t5_retry", 32'(o_retry_cnt), 32'(0));
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("t5_ready_idle", 32'(o_frame_ready), 32'(1));
    repeat (20) @(posedge i_clk);
    #1;
    check("t5_no_pulse", 32'(cnt_done + cnt_fail), 32'(0));

    // 6) drop in IDLE, sof stored in FILL, arq_en toggled mid-frame
    clear_stats();
    ack_cfg[0] = 4'b1010;
    put_byte(8'h11, 1'b0, 1'b1);
    put_byte(8'h5A, 1'b1, 1'b1);
    put_byte(8'h22, 1'b1, 1'b0);
    put_byte(8'h33, 1'b0, 1'b0);
    put_byte(8'h44, 1'b0, 1'b0);
    wait_end();
    check("t6_bits", cap[0], 32'h4433225A);
    check("t6_done", 32'(cnt_done), 32'(1));
    check("t6_arq_latched", 32'(m_arq), 32'(1));
    check("t6_retry", 32'(o_retry_cnt), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
